// File: rtl/palu_sched.sv
// Round-robin scheduler sharing one eightbit_palu between two requesters.
// Operands are latched toward the PALU, the result is captured after ALU_LAT cycles and returned tagged.
//
// state | meaning
// IDLE  | arbitrate requesters, accept one operation
// EXEC  | PALU inputs stable, settle timer counting down
// RESP  | captured result held until the consumer accepts it
module palu_sched #(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic [1:0] palu_s,
    output logic [7:0] palu_a,
    output logic [7:0] palu_b,
    input  logic [7:0] palu_f,
    input  logic       palu_ovf,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_f,
    output logic       rsp_ovf,
    input  logic       rsp_ready,
    output logic       busy,
    output logic [7:0] ovf_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

    state_t     state;
    logic       last_grant;
    logic [1:0] lat_cnt;
    logic       any_valid;
    logic       grant;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && any_valid && !grant;
    assign req1_ready = (state == IDLE) && any_valid &&  grant;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_cnt    <= '0;
            palu_s     <= '0;
            palu_a     <= '0;
            palu_b     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_f      <= '0;
            rsp_ovf    <= 1'b0;
            ovf_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        palu_s     <= grant ? req1_op : req0_op;
                        palu_a     <= grant ? req1_a  : req0_a;
                        palu_b     <= grant ? req1_b  : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        lat_cnt    <= LAT_LOAD;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end else begin
                        rsp_f     <= palu_f;
                        rsp_ovf   <= palu_ovf;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (rsp_ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palu_sched.sv
// Scoreboard bench for palu_sched: expected responses are queued by the stimulus and popped by a monitor.
// A second instance with ALU_LAT=3 covers the latency parameter.
module tb_palu_sched;

    typedef struct packed {
        logic       id;
        logic [7:0] f;
        logic       ovf;
    } rsp_t;

    logic clk, rst_n;

    logic       r0v, r0r, r1v, r1r;
    logic [1:0] r0op, r1op, ps;
    logic [7:0] r0a, r0b, r1a, r1b, pa, pb, pf, rf, oc;
    logic       povf, rv, rid, rovf, rr, busy;

    logic       v_3, rdy0_3, rdy1_3;
    logic [1:0] op_3, ps_3;
    logic [7:0] a_3, b_3, pa_3, pb_3, pf_3, rf_3, oc_3;
    logic       povf_3, rv_3, rid_3, rovf_3, rr_3, busy_3;

    int   errors = 0;
    int   checks = 0;
    rsp_t sb_q[$];

    palu_sched #(.ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
        .req1_valid(r1v), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
        .palu_s(ps), .palu_a(pa), .palu_b(pb), .palu_f(pf), .palu_ovf(povf),
        .rsp_valid(rv), .rsp_id(rid), .rsp_f(rf), .rsp_ovf(rovf), .rsp_ready(rr),
        .busy(busy), .ovf_count(oc)
    );

    palu_sched #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v_3), .req0_op(op_3), .req0_a(a_3), .req0_b(b_3), .req0_ready(rdy0_3),
        .req1_valid(1'b0), .req1_op(2'b00), .req1_a(8'h00), .req1_b(8'h00), .req1_ready(rdy1_3),
        .palu_s(ps_3), .palu_a(pa_3), .palu_b(pb_3), .palu_f(pf_3), .palu_ovf(povf_3),
        .rsp_valid(rv_3), .rsp_id(rid_3), .rsp_f(rf_3), .rsp_ovf(rovf_3), .rsp_ready(rr_3),
        .busy(busy_3), .ovf_count(oc_3)
    );

    // PALU stub: 00 add with carry out, 01 subtract, others pass a
    always_comb begin
        case (ps)
            2'b00:   {povf, pf} = {1'b0, pa} + {1'b0, pb};
            2'b01:   {povf, pf} = {1'b0, pa - pb};
            default: {povf, pf} = {1'b0, pa};
        endcase
        case (ps_3)
            2'b00:   {povf_3, pf_3} = {1'b0, pa_3} + {1'b0, pb_3};
            2'b01:   {povf_3, pf_3} = {1'b0, pa_3 - pb_3};
            default: {povf_3, pf_3} = {1'b0, pa_3};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rv && rr) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual id=%0d f=%0h required no response", rid, rf);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_id", 32'(rid), 32'(e.id));
                check("rsp_f", 32'(rf), 32'(e.f));
                check("rsp_ovf", 32'(rovf), 32'(e.ovf));
            end
        end
    end

    task automatic expect_rsp(input logic id, input logic [7:0] f, input logic ovf);
        rsp_t e;
        e.id = id; e.f = f; e.ovf = ovf;
        sb_q.push_back(e);
    endtask

    // Holds valid until ready is seen; returns 1 ns after the handshake edge.
    task automatic send(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic got;
        if (id == 1'b0) begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; end
        else            begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; end
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = id ? r1r : r0r;
        end
        check(id ? "req1_ready_seen" : "req0_ready_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id == 1'b0) r0v = 1'b0; else r1v = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; rr = 1'b1; rr_3 = 1'b1;
        r0v = 1'b0; r0op = '0; r0a = '0; r0b = '0;
        r1v = 1'b0; r1op = '0; r1a = '0; r1b = '0;
        v_3 = 1'b0; op_3 = '0; a_3 = '0; b_3 = '0;
        #12;
        check("reset_palu", {ps, pa, pb}, 32'd0);
        check("reset_rsp", {rv, rid, rf, rovf}, 32'd0);
        check("reset_busy_ovfcnt", {busy, oc}, 32'd0);
        check("reset_ready", {r0r, r1r}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // latency parameter on the ALU_LAT=3 instance
        v_3 = 1'b1; op_3 = 2'b01; a_3 = 8'h05; b_3 = 8'h03;
        @(negedge clk);
        check("lat3_ready_at_T", 32'(rdy0_3), 32'd1);
        @(posedge clk); #1 v_3 = 1'b0;
        check("lat3_palu_a_T1", 32'(pa_3), 32'h05);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("lat3_no_rsp_before_T4", 32'(rv_3), 32'd0);
        end
        @(negedge clk);
        check("lat3_rsp_valid_T4", 32'(rv_3), 32'd1);
        check("lat3_rsp_f", 32'(rf_3), 32'h02);
        check("lat3_rsp_id_ovf", {rid_3, rovf_3}, 32'd0);
        @(posedge clk); #1;

        // tie arbitration: expected order 0,1,0
        expect_rsp(1'b0, 8'h03, 1'b0);
        expect_rsp(1'b1, 8'h30, 1'b0);
        expect_rsp(1'b0, 8'h0A, 1'b0);
        fork
            begin
                send(1'b0, 2'b00, 8'h01, 8'h02);
                send(1'b0, 2'b00, 8'h05, 8'h05);
            end
            send(1'b1, 2'b00, 8'h10, 8'h20);
        join
        drain();

        // single op, ALU_LAT=1
        expect_rsp(1'b0, 8'h23, 1'b0);
        send(1'b0, 2'b00, 8'h12, 8'h11);
        check("single_palu_a_T1", 32'(pa), 32'h12);
        check("single_busy_T1", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_no_rsp_T1", 32'(rv), 32'd0);
        @(negedge clk);
        check("single_rsp_valid_T2", 32'(rv), 32'd1);
        drain();
        check("single_idle_after", 32'(busy), 32'd0);

        // backpressure with req1 waiting
        expect_rsp(1'b0, 8'h41, 1'b0);
        expect_rsp(1'b1, 8'h05, 1'b0);
        rr = 1'b0;
        send(1'b0, 2'b00, 8'h40, 8'h01);
        r1v = 1'b1; r1op = 2'b01; r1a = 8'h09; r1b = 8'h04;
        @(negedge clk);
        check("bp_exec_no_ready", {r0r, r1r}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid_held", 32'(rv), 32'd1);
            check("bp_rsp_f_held", 32'(rf), 32'h41);
            check("bp_busy_ready", {busy, r0r, r1r}, 32'b100);
        end
        @(posedge clk); #1 rr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_next_cycle", {busy, r1r}, 32'b01);
        @(posedge clk); #1 r1v = 1'b0;
        drain();

        // overflow counting and saturation
        for (int i = 0; i < 3; i++) begin
            expect_rsp(1'b0, 8'h10, 1'b1);
            send(1'b0, 2'b00, 8'hF0, 8'h20);
            drain();
        end
        check("ovf_count_3", 32'(oc), 32'd3);
        for (int i = 0; i < 252; i++) begin
            expect_rsp(1'b1, 8'h00, 1'b1);
            send(1'b1, 2'b00, 8'h80, 8'h80);
            drain();
        end
        check("ovf_count_255", 32'(oc), 32'd255);
        for (int i = 0; i < 2; i++) begin
            expect_rsp(1'b0, 8'h10, 1'b1);
            send(1'b0, 2'b00, 8'hF0, 8'h20);
            drain();
        end
        check("ovf_count_sat", 32'(oc), 32'd255);

        // reset during EXEC discards the operation
        send(1'b0, 2'b00, 8'h01, 8'h01);
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_palu", {ps, pa, pb}, 32'd0);
        check("rst_async_rsp", {rv, rid, rf, rovf}, 32'd0);
        check("rst_async_busy_ovfcnt", {busy, oc}, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_rsp_after", 32'(rv), 32'd0);
        end
        @(posedge clk); #1;
        expect_rsp(1'b0, 8'h33, 1'b0);
        send(1'b0, 2'b00, 8'h11, 8'h22);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palu_sched.md
# palu_sched

Round-robin scheduler that shares one `eightbit_palu` instance between two requesters. Each requester submits an operation over a valid/ready handshake. The scheduler latches the opcode and operands into registers that drive the PALU, waits a fixed settle time, and captures `f`/`ovf`. It then returns the result, tagged with the requester ID, over a valid/ready response port. It sits between the board/test front end and the PALU datapath, and a `palu_top`-style wrapper instantiates both.

## Interface
- `ALU_LAT`, default 1: cycles between driving PALU inputs and capturing its outputs. Legal range is 1..4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_op` in 2: requester 0 opcode, forwarded unchanged to PALU `s`.
- `req0_a`, `req0_b` in 8 each: requester 0 operands.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req1_valid`, `req1_op`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `palu_s` out 2, `palu_a` out 8, `palu_b` out 8: registered drive to PALU `s`/`a`/`b`.
- `palu_f` in 8, `palu_ovf` in 1: PALU combinational result and overflow flag.
- `rsp_valid` out 1: response held.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_f` out 8: captured result.
- `rsp_ovf` out 1: captured overflow.
- `rsp_ready` in 1: consumer accepts the response.
- `busy` out 1: high in any state other than IDLE.
- `ovf_count` out 8: saturating count of responses delivered with `rsp_ovf`=1.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Arbitrate between the requesters.
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester that is not `last_grant`.
  - Ready is combinational: `reqN_ready` = (state==IDLE) & grant==N. At most one ready is high per cycle.
  - On the handshake (valid & ready):
    - Register op/a/b into `palu_s/a/b`.
    - Set the ID register to N and set `last_grant`=N.
    - Load the counter with `ALU_LAT`-1 and go to EXEC.
- **EXEC**
  - `palu_*` stay stable.
  - While the counter is nonzero, decrement it.
  - When it is zero, capture `palu_f`→`rsp_f` and `palu_ovf`→`rsp_ovf`, then go to RESP.
- **RESP**
  - `rsp_valid`=1, and `rsp_id/f/ovf` are stable until the handshake.
  - On `rsp_valid & rsp_ready`:
    - Go to IDLE.
    - If `rsp_ovf`, increment `ovf_count`, saturating at 255.
- `reqN_*` inputs are ignored outside IDLE. Requesters hold their valid/data until they see ready.
- In IDLE, `palu_*` keep the last issued values and do not follow the request inputs.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, `last_grant`=1 (so requester 0 wins the first tie).
  - `palu_s/a/b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_f`=0, `rsp_ovf`=0.
  - `busy`=0, `ovf_count`=0, both `reqN_ready`=0.
- Cycle timeline, with the request handshake at the rising edge ending cycle T:
  - `palu_*` hold the new operands from T+1.
  - Capture happens at the edge ending cycle T+`ALU_LAT`.
  - `rsp_valid`=1 from T+`ALU_LAT`+1.
- Latency from request handshake to `rsp_valid` is `ALU_LAT`+1 cycles. With `ALU_LAT`=1: accept T, EXEC T+1, RESP T+2.
- Response handshake at cycle R: IDLE at R+1, and a new request can be accepted at R+1.
- Minimum issue interval is `ALU_LAT`+2 cycles when `rsp_ready` is held high.
- Backpressure: with `rsp_ready`=0, RESP holds indefinitely and no new requests are accepted. Both readies stay 0.
- Simultaneous requests in IDLE: exactly one is granted per round-robin. The loser keeps valid and is granted at the next IDLE if still valid, so neither requester is starved.
- A requester may reassert valid in the cycle after its own handshake. It wins only if the other requester is not valid.
- `ovf_count` at 255 stays 255.
- `rst_n` low at any time, including mid-EXEC or RESP, immediately forces all reset values. The in-flight operation is discarded and no response is produced.

## Test plan
Use a combinational PALU stub with s=00 → f=a+b and ovf=carry, and s=01 → f=a−b.
- **Single op, `ALU_LAT`=1:** req0 op=00, a=0x12, b=0x11 at T.
  - `req0_ready`=1 at T.
  - `palu_a`=0x12 at T+1.
  - `rsp_valid`=1 at T+2 with id=0, f=0x23, ovf=0.
- **Tie arbitration:** both valid from reset, `rsp_ready`=1.
  - req0 is granted first.
  - req1 is granted at the next IDLE.
  - req0 (re-asserted) is granted third. `rsp_id` sequence is 0,1,0.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`/`rsp_f` stay stable.
  - `busy`=1 and both readies stay 0.
  - On `rsp_ready`=1, IDLE follows the next cycle.
- **Overflow counting:** run 0xF0+0x20 three times.
  - `rsp_f`=0x10 and `rsp_ovf`=1 each time.
  - `ovf_count`=3.
  - Preload to 255 via 255 ovf ops: `ovf_count` stays 255.
- **Latency parameter:** with `ALU_LAT`=3, op 01 a=0x05 b=0x03 produces `rsp_valid` at T+4 with f=0x02.
- **Reset mid-op:** `rst_n` pulsed low during EXEC.
  - All outputs return to reset values asynchronously.
  - No `rsp_valid` appears afterwards.
  - The next request completes normally.
